// File: rtl/inst_rom_loader.sv
// Boot loader: streams a big-endian word count plus image into the instruction ROM and
// holds the core in reset until done. Define INST_ROM_LOADER_CHECKSUM_EN for a trailing XOR byte.
module inst_rom_loader #(
    parameter int ADDR_W = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        start,
    output logic        rom_we,
    output logic [31:0] rom_waddr,
    output logic [31:0] rom_wdata,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_DATA = 3'd1,
        ST_CSUM = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic [32:0]     MAX_N    = 33'd1 << ADDR_W;
    localparam logic [ADDR_W:0] IDX_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] IDX_ONE  = {{ADDR_W{1'b0}}, 1'b1};
`ifdef INST_ROM_LOADER_CHECKSUM_EN
    localparam state_t ST_TAIL = ST_CSUM;
`else
    localparam state_t ST_TAIL = ST_DONE;
`endif

    state_t          state_q, state_d;
    logic [1:0]      bcnt_q, bcnt_d;
    logic [23:0]     shift_q, shift_d;
    logic [ADDR_W:0] idx_q, idx_d;
    logic [ADDR_W:0] n_q, n_d;
    logic            we_q, we_d;
    logic [31:0]     waddr_q, waddr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            cpu_rst_q, cpu_rst_d;
    logic [31:0]     word_s;
    logic            acc_s;
`ifdef INST_ROM_LOADER_CHECKSUM_EN
    logic [7:0]      csum_q, csum_d;
`endif

    // Next-state and next-output logic for the load sequence
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        n_d     = n_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
`ifdef INST_ROM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        word_s  = {shift_q, s_data};
        acc_s   = s_valid && ready_q;
        case (state_q)
            ST_HDR: begin
                if (acc_s) begin
                    shift_d = word_s[23:0];
                    bcnt_d  = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        if (word_s == 32'd0) begin
                            state_d = ST_TAIL;
                        end else if ({1'b0, word_s} > MAX_N) begin
                            state_d = ST_ERR;
                        end else begin
                            state_d = ST_DATA;
                            n_d     = word_s[ADDR_W:0];
                            idx_d   = IDX_ZERO;
                        end
                    end else begin
                        state_d = ST_HDR;
                    end
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_DATA: begin
                if (acc_s) begin
                    shift_d = word_s[23:0];
                    bcnt_d  = bcnt_q + 2'd1;
`ifdef INST_ROM_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ s_data;
`endif
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        waddr_d = 32'({idx_q, 2'b00});
                        wdata_d = word_s;
                        idx_d   = idx_q + IDX_ONE;
                        // idx is one bit wider than the ROM index so N = 2^ADDR_W compares cleanly
                        if (idx_q == (n_q - IDX_ONE)) begin
                            state_d = ST_TAIL;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef INST_ROM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (acc_s) begin
                    state_d = (s_data == csum_q) ? ST_DONE : ST_ERR;
                end else begin
                    state_d = ST_CSUM;
                end
            end
`endif
            ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_HDR;
                    bcnt_d  = 2'd0;
                    idx_d   = IDX_ZERO;
                    n_d     = IDX_ZERO;
`ifdef INST_ROM_LOADER_CHECKSUM_EN
                    csum_d  = 8'd0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase
        ready_d   = (state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_CSUM);
        busy_d    = ready_d;
        done_d    = (state_d == ST_DONE);
        err_d     = (state_d == ST_ERR);
        // Core stays in reset through the final write strobe, releasing one cycle after it
        cpu_rst_d = (state_d != ST_DONE) || we_d;
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_HDR;
            bcnt_q    <= 2'd0;
            shift_q   <= 24'd0;
            idx_q     <= IDX_ZERO;
            n_q       <= IDX_ZERO;
            we_q      <= 1'b0;
            waddr_q   <= 32'd0;
            wdata_q   <= 32'd0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
`ifdef INST_ROM_LOADER_CHECKSUM_EN
            csum_q    <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            n_q       <= n_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cpu_rst_q <= cpu_rst_d;
`ifdef INST_ROM_LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign s_ready   = ready_q;
    assign rom_we    = we_q;
    assign rom_waddr = waddr_q;
    assign rom_wdata = wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Boot loader that sits directly upstream of the instruction ROM and CPU core in the minimal SOPC.
- Takes a byte stream (valid/ready) carrying a word count followed by big-endian 32-bit instructions, and writes each word into the instruction ROM write port.
- Holds the CPU core in reset until the image is fully written.
- Replaces bench-side preloading of the ROM, so the same SOPC can be booted from a host link.

Parameters:
ADDR_W, 17, log2 of ROM depth in words; maximum image = 2^ADDR_W words

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
s_data  input  8  stream byte
s_valid  input  1  s_data valid
s_ready  output  1  loader accepts byte this cycle
start  input  1  single-cycle pulse; restarts a load from DONE or ERR
rom_we  output  1  ROM write strobe, one cycle per word
rom_waddr  output  32  ROM byte address of the word (word index << 2)
rom_wdata  output  32  ROM write data
cpu_rst  output  1  active-high reset to core (1 = core held in reset)
busy  output  1  1 in HDR/DATA(/CSUM)
done  output  1  1 in DONE
err  output  1  1 in ERR

Behaviour:
- Byte transfer occurs when s_valid && s_ready. Bytes presented while s_ready=0 are ignored, not buffered.
- States and transitions:
  - HDR: collect 4 bytes as a big-endian word count N (first byte = MSB).
    - After the 4th byte: N == 0 -> DONE; N > 2^ADDR_W -> ERR; otherwise -> DATA with word index = 0.
  - DATA: collect 4 bytes per word, MSB first.
    - On acceptance of the 4th byte: next cycle rom_we=1 for exactly one cycle, rom_wdata = assembled word, rom_waddr = index<<2; index increments.
    - After word N-1 is accepted: -> DONE (or CSUM when the optional feature is enabled).
  - DONE: cpu_rst=0, s_ready=0. start -> HDR.
  - ERR: cpu_rst=1, s_ready=0. start -> HDR.
- s_ready=1 in HDR and DATA (and CSUM); 0 elsewhere. Back-to-back bytes sustain one byte per cycle; s_valid gaps of any length are tolerated.
- cpu_rst:
  - 1 in HDR, DATA, CSUM, ERR.
  - Falls to 0 exactly one clock after the final rom_we pulse; for N=0, one clock after the 4th header byte.
- start:
  - Pulse in DONE/ERR: cpu_rst rises the following cycle; byte counter, word index and N are cleared.
  - Ignored in HDR/DATA/CSUM.
- Async reset (rst=0), any time including mid-load:
  - State=HDR, byte/word counters=0, rom_we=0, rom_waddr=0, rom_wdata=0, cpu_rst=1, done=0, err=0, busy=1.
  - s_ready is 0 while rst is 0 and rises the first cycle after rst releases.
  - A partial word is discarded, never written.
- rom_waddr/rom_wdata hold their last values between strobes.
- Index counter is ADDR_W+1 bits wide so that N = 2^ADDR_W does not wrap before the compare. The last written address is (2^ADDR_W-1)<<2.

Optional Feature:
- Macro: INST_ROM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data word, state CSUM accepts one byte.
  - Expected value = XOR of all 4N data bytes (header excluded; 0x00 when N=0, in which case CSUM follows HDR).
  - Match -> DONE (cpu_rst falls next cycle); mismatch -> ERR.
  - Words are still written to ROM as received.
- Undefined: no CSUM state, no checksum byte; DATA -> DONE directly.

Test Plan:
- Reset value check: hold rst=0 mid-cycle.
  -> All outputs at reset values (cpu_rst=1, rom_we=0, s_ready=0, busy=1); s_ready=1 one cycle after release.
- Basic load: bytes 00 00 00 02, 34 01 11 00, 34 02 00 20 back-to-back.
  -> rom_we pulses with (addr 0x0, data 0x34011100) then (addr 0x4, data 0x34020020).
  -> cpu_rst=0 one cycle after the second pulse; done=1.
- Throttled stream: same image with s_valid toggling 1/0 randomly.
  -> Identical writes and final state; no duplicated or skipped bytes.
- N=0: bytes 00 00 00 00.
  -> No rom_we; done=1; cpu_rst=0 one cycle after the 4th byte.
  -> With checksum enabled, the byte 00 is required before DONE.
- Oversize and restart: ADDR_W=4, N=0x11.
  -> err=1, cpu_rst=1, s_ready=0.
  -> Pulse start: busy=1; a subsequent valid N=1 load succeeds.
- Reset mid-word: assert rst after 2 data bytes of word 1.
  -> No write for that word; after release a full reload writes from addr 0.
- Checksum enabled: N=1, word 12 34 56 78.
  -> Checksum byte 0x08 -> done=1; checksum byte 0x09 -> err=1, cpu_rst stays 1.
